// File: rtl/dphy_tx_serializer_n.sv
// D-PHY TX HS serializer: parallel words in over valid/ready, OUT_W-bit slices
// out per clock, LSB-first or MSB-first, with a one-word hold buffer plus a
// bypass path so back-to-back words stream without idle cycles.
module dphy_tx_serializer_n #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OUT_W     = 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              TX_DDR_clk,
    input  logic              TX_rst,
    input  logic              Enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [OUT_W-1:0]  ser_out,
    output logic              ser_valid,
    output logic              byte_done,
    output logic              underrun
);

    localparam int unsigned SLOTS = DATA_W / OUT_W;
    localparam int unsigned CNT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state,     state_nxt;
    logic [DATA_W-1:0] shreg,     shreg_nxt;
    logic [DATA_W-1:0] hold_reg,  hold_reg_nxt;
    logic              hold_full, hold_full_nxt;
    logic [CNT_W-1:0]  slot_cnt,  slot_cnt_nxt;
    logic              underrun_nxt;

    logic              accept;
    logic              last_slot;
    logic [DATA_W-1:0] shreg_shifted;

    // Handshake and status outputs, combinational from registers and inputs
    always_comb begin
        in_ready  = Enable & ~hold_full & ~TX_rst;
        accept    = in_valid & in_ready;
        last_slot = (slot_cnt == LAST_SLOT);
        ser_valid = (state == SHIFT);
        byte_done = (state == SHIFT) & last_slot;
    end

    // Slice selection: first-transmitted bit always lands in ser_out[0]
    always_comb begin
        ser_out = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (MSB_FIRST) ser_out[i] = shreg[DATA_W-1-i];
            else           ser_out[i] = shreg[i];
        end
        if (MSB_FIRST) shreg_shifted = shreg << OUT_W;
        else           shreg_shifted = shreg >> OUT_W;
    end

    // Next-state logic: Enable low flushes; the last slice reloads from hold,
    // then from the bypass path, otherwise returns to IDLE with an underrun
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        hold_reg_nxt  = hold_reg;
        hold_full_nxt = hold_full;
        slot_cnt_nxt  = slot_cnt;
        underrun_nxt  = 1'b0;

        if (!Enable) begin
            state_nxt     = IDLE;
            shreg_nxt     = '0;
            hold_full_nxt = 1'b0;
            slot_cnt_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shreg_nxt    = in_data;
                        slot_cnt_nxt = '0;
                        state_nxt    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_slot) begin
                        shreg_nxt    = shreg_shifted;
                        slot_cnt_nxt = slot_cnt + CNT_W'(1);
                        if (accept) begin
                            hold_reg_nxt  = in_data;
                            hold_full_nxt = 1'b1;
                        end
                    end else if (hold_full) begin
                        shreg_nxt     = hold_reg;
                        hold_full_nxt = 1'b0;
                        slot_cnt_nxt  = '0;
                    end else if (accept) begin
                        shreg_nxt    = in_data;
                        slot_cnt_nxt = '0;
                    end else begin
                        shreg_nxt    = '0;
                        slot_cnt_nxt = '0;
                        state_nxt    = IDLE;
                        underrun_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
        if (TX_rst) begin
            state     <= IDLE;
            shreg     <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            slot_cnt  <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            hold_reg  <= hold_reg_nxt;
            hold_full <= hold_full_nxt;
            slot_cnt  <= slot_cnt_nxt;
            underrun  <= underrun_nxt;
        end
    end

endmodule
